// File: rtl/lcd_multi.sv
`default_nettype none
// ============================================================================
// Module   : lcd_multi
// Purpose  : N-channel Game Boy LCD capture into private frame buffers and a
//            shared side-by-side scan-out raster with optional pixel scaling.
// Options  : LCD_MULTI_BORDER_EN - when defined, draws a 0x40 grey separator
//            bar in the last HSCALE columns of every channel but the rightmost.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_multi #(
  parameter int CHANNELS = 2,
  parameter int HSCALE   = 1,
  parameter int VSCALE   = 1,
  parameter int HFP      = 8,
  parameter int HSW      = 32,
  parameter int HBP      = 24,
  parameter int VPRE     = 48,
  parameter int VPOST    = 48,
  parameter int VFP      = 4,
  parameter int VSW      = 3,
  parameter int VBP      = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    pce,
  input  logic [CHANNELS-1:0]     clkena,
  input  logic [15*CHANNELS-1:0]  data,
  input  logic [2*CHANNELS-1:0]   mode,
  input  logic [CHANNELS-1:0]     on,
  input  logic                    isGBC,
  input  logic                    inv,
  output logic                    hs,
  output logic                    vs,
  output logic                    blank,
  output logic [7:0]              r,
  output logic [7:0]              g,
  output logic [7:0]              b,
  output logic [CHANNELS-1:0]     ovf
);

  localparam int          C_HV_I    = CHANNELS * 160 * HSCALE;
  localparam int          C_VV_I    = 144 * VSCALE;
  localparam logic [15:0] C_HV      = 16'(C_HV_I);
  localparam logic [15:0] C_CW      = 16'(160 * HSCALE);
  localparam logic [15:0] C_HTOT_M1 = 16'(C_HV_I + HFP + HSW + HBP - 1);
  localparam logic [15:0] C_HS_ON   = 16'(C_HV_I + HFP);
  localparam logic [15:0] C_HS_OFF  = 16'(C_HV_I + HFP + HSW);
  localparam logic [15:0] C_VTOP    = 16'(VPRE);
  localparam logic [15:0] C_VEND    = 16'(VPRE + C_VV_I);
  localparam logic [15:0] C_VS_ON   = 16'(VPRE + C_VV_I + VPOST + VFP);
  localparam logic [15:0] C_VS_OFF  = 16'(VPRE + C_VV_I + VPOST + VFP + VSW);
  localparam logic [15:0] C_VTOT_M1 = 16'(VPRE + C_VV_I + VPOST + VFP + VSW + VBP - 1);
  localparam logic [14:0] C_LAST    = 15'd23039;

  logic [15:0] r_h, r_v;
  logic        w_vis, w_hs, w_vs, w_border;
  logic [1:0]  w_chan;
  logic [15:0] w_hx, w_x, w_yl, w_y;
  logic [14:0] w_addr;
  logic [14:0] w_q [CHANNELS];
  logic        r_vis1, r_hs1, r_vs1, r_bord1;
  logic [1:0]  r_chan1;
  logic [14:0] w_p;
  logic [9:0]  w_r5, w_g5, w_b5;
  logic [1:0]  w_s;
  logic [7:0]  w_r, w_g, w_b;

  // ---------------------------------------------------------------- capture
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [14:0] r_mem [23040];
    logic [14:0] r_wp;
    logic        r_ovf;
    logic [14:0] r_q;
    logic        w_idle;

    // Pointer is parked at 0 whenever the LCD is off or in vblank
    assign w_idle = !on[c] || (mode[2*c +: 2] == 2'b01);

    // Write pointer advance, saturation at the last pixel, sticky overflow
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_wp  <= '0;
        r_ovf <= 1'b0;
      end else if (w_idle) begin
        r_wp  <= '0;
        r_ovf <= 1'b0;
      end else if (clkena[c]) begin
        if (r_wp == C_LAST) r_ovf <= 1'b1;
        else                r_wp  <= r_wp + 15'd1;
      end
    end

    // Frame buffer: port A captures, port B reads old data on a collision
    always_ff @(posedge clk) begin
      if (clkena[c] && !w_idle) r_mem[r_wp] <= data[15*c +: 15];
      if (pce)                  r_q <= r_mem[w_addr];
    end

    assign w_q[c] = r_q;
    assign ovf[c] = r_ovf;
  end

  // --------------------------------------------------------------- scan-out
  // Raster position counters, advanced once per pixel clock enable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (pce) begin
      if (r_h == C_HTOT_M1) begin
        r_h <= '0;
        r_v <= (r_v == C_VTOT_M1) ? 16'd0 : r_v + 16'd1;
      end else begin
        r_h <= r_h + 16'd1;
      end
    end
  end

  // Read address and raw sync flags derived purely from the counters
  always_comb begin
    w_vis  = (r_h < C_HV) && (r_v >= C_VTOP) && (r_v < C_VEND);
    w_hs   = (r_h >= C_HS_ON) && (r_h < C_HS_OFF);
    w_vs   = (r_v >= C_VS_ON) && (r_v < C_VS_OFF);
    w_chan = 2'(r_h / C_CW);
    w_hx   = r_h % C_CW;
    w_x    = (HSCALE == 2) ? (w_hx >> 1) : w_hx;
    w_yl   = r_v - C_VTOP;
    w_y    = (VSCALE == 2) ? (w_yl >> 1) : w_yl;
    w_addr = '0;
    if (w_vis) w_addr = 15'(w_y * 16'd160 + w_x);
`ifdef LCD_MULTI_BORDER_EN
    w_border = (CHANNELS > 1) && (32'(w_chan) != CHANNELS - 1) &&
               (w_hx >= C_CW - 16'(HSCALE));
`else
    w_border = 1'b0;
`endif
  end

  // Stage 1: controls travel alongside the RAM read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vis1  <= 1'b0;
      r_hs1   <= 1'b0;
      r_vs1   <= 1'b0;
      r_bord1 <= 1'b0;
      r_chan1 <= '0;
    end else if (pce) begin
      r_vis1  <= w_vis;
      r_hs1   <= w_hs;
      r_vs1   <= w_vs;
      r_bord1 <= w_border && w_vis;
      r_chan1 <= w_chan;
    end
  end

  // Channel select and colour decode of the word returned by the RAM
  always_comb begin
    w_p = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (r_chan1 == 2'(c)) w_p = on[c] ? w_q[c] : 15'd0;
    end
    w_r5 = {5'd0, w_p[4:0]};
    w_g5 = {5'd0, w_p[9:5]};
    w_b5 = {5'd0, w_p[14:10]};
    w_s  = w_p[1:0] ^ {inv, inv};
    if (isGBC) begin
      w_r = 8'((10'd13 * w_r5 + 10'd2 * w_g5 + w_b5) >> 1);
      w_g = {7'(10'd3 * w_g5 + w_b5), 1'b0};
      w_b = 8'((10'd3 * w_r5 + 10'd2 * w_g5 + 10'd11 * w_b5) >> 1);
    end else begin
      case (w_s)
        2'd0:    w_r = 8'd252;
        2'd1:    w_r = 8'd168;
        2'd2:    w_r = 8'd96;
        default: w_r = 8'd0;
      endcase
      w_g = w_r;
      w_b = w_r;
    end
  end

  // Stage 2: registered video outputs, black outside the visible window
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs    <= 1'b0;
      vs    <= 1'b0;
      blank <= 1'b1;
      r     <= '0;
      g     <= '0;
      b     <= '0;
    end else if (pce) begin
      hs    <= r_hs1;
      vs    <= r_vs1;
      blank <= !r_vis1;
      if (!r_vis1) begin
        r <= '0; g <= '0; b <= '0;
      end else if (r_bord1) begin
        r <= 8'h40; g <= 8'h40; b <= 8'h40;
      end else begin
        r <= w_r; g <= w_g; b <= w_b;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_multi
// Purpose  : Directed self-checking bench for lcd_multi: a 2-channel unscaled
//            instance and a 1-channel 2x2-scaled instance share clk/pce/reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_multi;

  localparam int HV    = 320;
  localparam int HFP   = 4;
  localparam int HSW   = 8;
  localparam int HTOT  = 336;
  localparam int VTOT  = 151;
`ifdef LCD_MULTI_BORDER_EN
  localparam int EXP_C0_LAST = 8'h40;
`else
  localparam int EXP_C0_LAST = 252;
`endif

  logic        clk = 1'b0;
  logic        reset_n, pce, isGBC, inv;
  logic [1:0]  clkena, mode, on, ovf;
  logic [3:0]  mode_w;
  logic [29:0] data;
  logic        hs, vs, blank;
  logic [7:0]  r, g, b;

  logic        clkena2, on2, gbc2, inv2, ovf2;
  logic [1:0]  mode2;
  logic [14:0] data2;
  logic        hs2, vs2, blank2;
  logic [7:0]  r2, g2, b2;

  int n_vectors = 0;
  int n_miscompares = 0;
  int cyc;

  assign mode = 2'b00;

  lcd_multi #(
    .CHANNELS(2), .HSCALE(1), .VSCALE(1), .HFP(HFP), .HSW(HSW), .HBP(4),
    .VPRE(2), .VPOST(2), .VFP(1), .VSW(1), .VBP(1)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .pce(pce), .clkena(clkena), .data(data),
    .mode(mode_w), .on(on), .isGBC(isGBC), .inv(inv), .hs(hs), .vs(vs),
    .blank(blank), .r(r), .g(g), .b(b), .ovf(ovf)
  );

  lcd_multi #(
    .CHANNELS(1), .HSCALE(2), .VSCALE(2), .HFP(HFP), .HSW(HSW), .HBP(4),
    .VPRE(2), .VPOST(2), .VFP(1), .VSW(1), .VBP(1)
  ) u_dut2 (
    .clk(clk), .reset_n(reset_n), .pce(pce), .clkena(clkena2), .data(data2),
    .mode(mode2), .on(on2), .isGBC(gbc2), .inv(inv2), .hs(hs2), .vs(vs2),
    .blank(blank2), .r(r2), .g(g2), .b(b2), .ovf(ovf2)
  );

  always #5 clk = ~clk;

  // Bench-side count of pixel clocks since reset release
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait until outputs reflect raster position (v,h): two pce cycles of latency
  task automatic wait_pos(input int v, input int h);
    int target;
    target = v * HTOT + h + 2;
    if (cyc > target) check("schedule", 32'(cyc), 32'(target));
    while (cyc < target) @(negedge clk);
  endtask

  function automatic logic [14:0] ch0_pix(input int i);
    int ln, x;
    ln = i / 160;
    x  = i % 160;
    case (ln)
      0: ch0_pix = 15'h0000;
      1: ch0_pix = (x == 0) ? 15'h7FFF : (x == 1) ? 15'h001F :
                   (x == 2) ? 15'h03E0 : (x == 3) ? 15'h7C00 : 15'h0000;
      2, 3: ch0_pix = 15'd3;
      default: ch0_pix = 15'd1;
    endcase
  endfunction

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: run exceeded cycle budget");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; pce = 1'b1; clkena = '0; data = '0; mode_w = '0;
    on = 2'b11; isGBC = 1'b0; inv = 1'b0;
    clkena2 = 1'b0; data2 = '0; mode2 = '0; on2 = 1'b1; gbc2 = 1'b0; inv2 = 1'b0;

    repeat (4) @(negedge clk);
    check("rst_hs",     32'(hs),     0);
    check("rst_vs",     32'(vs),     0);
    check("rst_blank",  32'(blank),  1);
    check("rst_rgb",    32'({r, g, b}), 0);
    check("rst_ovf",    32'(ovf),    0);
    check("rst_blank2", 32'(blank2), 1);

    // First run up to the hsync edge, then an asynchronous reset mid-line
    reset_n = 1'b1;
    wait_pos(0, HV + HFP);
    check("hs_rise_pre", 32'(hs), 1);
    #2 reset_n = 1'b0;
    #1 check("async_rst_hs", 32'(hs), 0);
    repeat (3) @(negedge clk);
    check("rst_hold_blank", 32'(blank), 1);
    reset_n = 1'b1;

    fork
      // Capture: ch1 overruns its buffer, ch0 and dut2 fill a few lines
      begin
        for (int i = 0; i < 23041; i++) begin
          clkena[1] = 1'b1;
          data[29:15] = (i == 23039) ? 15'd1 : (i == 23040) ? 15'd2 : 15'd3;
          clkena[0] = (i < 800);
          data[14:0] = (i < 800) ? ch0_pix(i) : 15'd0;
          clkena2 = (i < 162);
          data2 = (i == 0) ? 15'd0 : (i == 160) ? 15'd2 : (i == 161) ? 15'd1 : 15'd3;
          @(negedge clk);
          if (i == 23038) check("ovf_before_last", 32'(ovf[1]), 0);
          if (i == 23039) check("ovf_at_last", 32'(ovf[1]), 1);
        end
        clkena = '0; clkena2 = 1'b0;
        @(negedge clk);
        check("ovf_sticky", 32'(ovf[1]), 1);
        check("ovf0_clear", 32'(ovf[0]), 0);
        check("ovf2_clear", 32'(ovf2),   0);
      end
      // Scan-out of the two-channel instance
      begin
        wait_pos(0, HV + HFP - 1);   check("hs_pre",  32'(hs), 0);
        wait_pos(0, HV + HFP);       check("hs_rise", 32'(hs), 1);
        wait_pos(0, HV + HFP + HSW - 1); check("hs_last", 32'(hs), 1);
        wait_pos(0, HV + HFP + HSW); check("hs_fall", 32'(hs), 0);
        wait_pos(1, 5);   check("vpre_blank", 32'(blank), 1);
                          check("vpre_rgb",   32'(r), 0);
        wait_pos(2, 0);   check("dmg_blank0", 32'(blank), 0);
                          check("dmg_c0_x0",  32'({r, g, b}), 32'h00FCFCFC);
        wait_pos(2, 159); check("dmg_c0_x159", 32'(r), EXP_C0_LAST);
        wait_pos(2, 160); check("dmg_c1_x0",   32'(r), 0);
        wait_pos(2, 319); check("dmg_c1_x159", 32'(r), 0);
        wait_pos(2, 320); check("hblank",      32'(blank), 1);
        wait_pos(2, 330); isGBC = 1'b1;
        wait_pos(3, 0);   check("gbc_white", 32'({r, g, b}), 32'h00F8F8F8);
        wait_pos(3, 1);   check("gbc_red",   32'({r, g, b}), 32'h00C9002E);
        wait_pos(3, 2);   check("gbc_green", 32'({r, g, b}), 32'h001FBA1F);
        wait_pos(3, 3);   check("gbc_blue",  32'({r, g, b}), 32'h000F3EAA);
        wait_pos(3, 160); check("gbc_c1",    32'({r, g, b}), 32'h00130004);
        wait_pos(3, 330); isGBC = 1'b0; on[0] = 1'b0;
        wait_pos(4, 5);   check("off_c0",     32'(r), 252);
        wait_pos(4, 165); check("off_c1_on",  32'(r), 0);
        wait_pos(4, 330); inv = 1'b1;
        wait_pos(5, 5);   check("off_c0_inv", 32'(r), 0);
        wait_pos(5, 165); check("inv_c1",     32'(r), 252);
        wait_pos(5, 330); on[0] = 1'b1;
        wait_pos(6, 5);   check("inv_c0_s1",  32'(r), 96);
        wait_pos(6, 200); check("inv_c1_s3",  32'(r), 252);
        wait_pos(6, 330); inv = 1'b0;
        wait_pos(145, 318); check("c1_addr23038", 32'(r), 0);
        wait_pos(145, 319); check("c1_addr23039", 32'({r, g, b}), 32'h00606060);
        wait_pos(146, 0);   check("vpost_blank",  32'(blank), 1);
        wait_pos(148, 0);   check("vs_pre",  32'(vs), 0);
        wait_pos(149, 0);   check("vs_on",   32'(vs), 1);
        wait_pos(150, 0);   check("vs_off",  32'(vs), 0);
      end
      // Scan-out of the 2x2-scaled instance
      begin
        wait_pos(1, 0);   check("s_vpre_blank", 32'(blank2), 1);
        wait_pos(2, 0);   check("s_y0_h0", 32'(r2), 252);
        wait_pos(2, 1);   check("s_y0_h1", 32'(r2), 252);
        wait_pos(2, 2);   check("s_y0_h2", 32'(r2), 0);
        wait_pos(2, 3);   check("s_y0_h3", 32'(r2), 0);
        wait_pos(3, 1);   check("s_y0b_h1", 32'(r2), 252);
        wait_pos(3, 2);   check("s_y0b_h2", 32'(r2), 0);
        wait_pos(4, 0);   check("s_y1_h0", 32'(r2), 96);
        wait_pos(4, 1);   check("s_y1_h1", 32'(r2), 96);
        wait_pos(4, 2);   check("s_y1_h2", 32'(r2), 168);
        wait_pos(4, 3);   check("s_y1_h3", 32'(r2), 168);
        wait_pos(4, 319); check("s_last_col", 32'(blank2), 0);
        wait_pos(4, 320); check("s_hblank",   32'(blank2), 1);
      end
    join

    // Vblank clears the overflow and rewinds the pointer to address 0
    check("ovf_hold", 32'(ovf[1]), 1);
    mode_w[3:2] = 2'b01;
    repeat (2) @(negedge clk);
    check("ovf_vblank_clr", 32'(ovf[1]), 0);
    mode_w[3:2] = 2'b00;
    clkena[1] = 1'b1; data[29:15] = 15'd2;
    @(negedge clk);
    clkena[1] = 1'b0;
    wait_pos(VTOT + 2, 0);   check("f2_c0_x0", 32'(r), 252);
    wait_pos(VTOT + 2, 160); check("f2_c1_x0_rewound", 32'(r), 96);
    wait_pos(VTOT + 2, 161); check("f2_c1_x1_kept", 32'(r), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
`default_nettype wire
